cc_cond_unit: RTL
=================

Name: cc_cond_unit

Overview:
- Sits directly downstream of the 64-bit execute ALU in the Y86-64 SEQ execute stage.
- Derives ZF/SF/OF from the ALU result and overflow output, and holds them in the condition-code register.
- Evaluates the branch/move condition (Cnd) for jXX and cmovXX from the stored flags.
- Cnd feeds PC-select and the register-write gating of cmovXX.

Parameters:
- W, 64, data width of alu_result.
- CNT_W, 32, width of the performance counters (used only with CC_PERF_EN).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- icode  in  4  instruction code of the instruction in execute.
- ifun  in  4  function code of the instruction in execute.
- alu_result  in  W  ALU result, signed.
- alu_overflow  in  1  ALU signed-overflow output.
- cc_inhibit  in  1  suppresses the CC update this cycle (exception / halt status).
- stall  in  1  freezes all state this cycle.
- zf  out  1  registered zero flag.
- sf  out  1  registered sign flag.
- of  out  1  registered overflow flag.
- cnd  out  1  condition result, combinational from registered flags.
- bad_cond  out  1  asserted for jXX/cmovXX with ifun > 6.

Behaviour:
- Reset (async, active-high): zf=1, sf=0, of=0. Counters = 0. Reset mid-cycle overrides any pending update immediately.
- set_cc = (icode==OPQ (4'h6)) & ~cc_inhibit & ~stall.
- Flag computation:
  - zf_next = (alu_result == 0).
  - sf_next = alu_result[W-1].
  - of_next = alu_overflow when ifun is ADD (0) or SUB (1); forced 0 for AND (2) and XOR (3).
  - OPq with ifun > 3: flags are not updated (treated as set_cc=0).
- Update timing: on the rising clk edge with set_cc=1, zf/sf/of take the *_next values. Otherwise they hold.
- Latency: flags are visible on outputs one cycle after the OPq edge. An OPq's own cnd never reflects its own result.
- Cnd is a function of the registered flags and ifun. It is valid only when icode is JXX (4'h7) or CMOVXX (4'h2); otherwise cnd=0.
- Cnd mapping by ifun:
  - 0: 1
  - 1 (le): (sf^of)|zf
  - 2 (l): sf^of
  - 3 (e): zf
  - 4 (ne): ~zf
  - 5 (ge): ~(sf^of)
  - 6 (g): ~(sf^of)&~zf
  - >6: cnd=0 and bad_cond=1.
- bad_cond=0 for every other icode.
- stall=1 takes priority over set_cc. cc_inhibit=1 blocks only the flag update; cnd is still evaluated.
- Back-to-back OPq: each edge overwrites the flags. No accumulation.
- Simultaneous set_cc and a new conditional instruction cannot occur (single instruction per cycle). No bypass path.

Optional Feature:
- CC_PERF_EN defined: adds outputs cc_upd_cnt[CNT_W-1:0] and taken_cnt[CNT_W-1:0].
  - cc_upd_cnt increments on every edge where set_cc=1.
  - taken_cnt increments on every non-stalled edge where icode==JXX and cnd=1.
  - Both wrap from all-ones to 0. Both hold under stall. Both clear on rst.
- CC_PERF_EN undefined: the ports and counters are absent. Flag and cnd behaviour is unchanged.

Decomposition:
- Shared package y86_pkg:
  - icode constants: OPQ=6, JXX=7, CMOVXX=2.
  - ALU function constants: ADD=0, SUB=1, AND=2, XOR=3.
  - Condition constants: C_YES=0, C_LE=1, C_L=2, C_E=3, C_NE=4, C_GE=5, C_G=6.
- One sub-module, cond_eval: purely combinational. Maps (ifun, zf, sf, of) to (cnd, bad_cond).
- The top level holds the flag register, the set_cc logic and the optional counters.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> zf=1, sf=0, of=0 immediately; JXX ifun=3 gives cnd=1.
- OPq ADD, alu_result=64'h8000_0000_0000_0000, alu_overflow=1 -> after the edge zf=0, sf=1, of=1; next JXX ifun=2 (l) gives cnd=0; ifun=1 (le) gives cnd=0.
- OPq XOR, alu_result=0, alu_overflow=1 -> zf=1, sf=0, of=0 (OF forced); CMOVXX ifun=3 gives cnd=1; ifun=4 gives cnd=0.
- OPq SUB, result=64'hFFFF_FFFF_FFFF_FFFE, overflow=0, with stall=1 then cc_inhibit=1 -> flags unchanged both cycles; third cycle with both low -> sf=1, zf=0; JXX ifun=2 gives cnd=1, ifun=6 gives cnd=0.
- JXX ifun=7 -> cnd=0, bad_cond=1. Non-conditional icode=3 with ifun=3 -> cnd=0, bad_cond=0.
- With CC_PERF_EN: 3 OPq updates plus 2 taken JXX, one of them stalled -> cc_upd_cnt=3, taken_cnt=1. Preload near wrap: counter at 32'hFFFF_FFFF plus one update -> 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute-stage condition-code logic.
package y86_pkg;

   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CMOVXX = 4'h2;

   localparam logic [3:0] ADD = 4'h0;
   localparam logic [3:0] SUB = 4'h1;
   localparam logic [3:0] AND = 4'h2;
   localparam logic [3:0] XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_flags_t;

   function automatic logic is_cond_icode(input logic [3:0] icode);
      return (icode == JXX) || (icode == CMOVXX);
   endfunction

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Combinational condition evaluator: (ifun, zf, sf, of) -> (cnd, bad_cond).
module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   output logic       cnd,
   output logic       bad_cond
);

   logic lt;

   assign lt = sf ^ of;

   always_comb begin
      cnd      = 1'b0;
      bad_cond = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: bad_cond = 1'b1;
      endcase
   end

endmodule

// File: rtl/cc_cond_unit.sv
// Y86-64 SEQ condition-code register and jXX/cmovXX condition evaluation.
// Optional performance counters are enabled by defining CC_PERF_EN.
module cc_cond_unit
   import y86_pkg::*;
#(
   parameter int W     = 64,
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [W-1:0]     alu_result,
   input  logic             alu_overflow,
   input  logic             cc_inhibit,
   input  logic             stall,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             cnd,
   output logic             bad_cond
`ifdef CC_PERF_EN
   ,
   output logic [CNT_W-1:0] cc_upd_cnt,
   output logic [CNT_W-1:0] taken_cnt
`endif
);

   cc_flags_t flags;
   cc_flags_t flags_next;
   logic      set_cc;
   logic      op_valid;
   logic      cnd_raw;
   logic      bad_raw;
   logic      is_cond;

   // OPq with an undefined function code leaves the flags untouched.
   always_comb begin
      op_valid      = 1'b1;
      flags_next.zf = (alu_result == '0);
      flags_next.sf = alu_result[W-1];
      flags_next.of = 1'b0;
      case (ifun)
         ADD, SUB: flags_next.of = alu_overflow;
         AND, XOR: flags_next.of = 1'b0;
         default:  op_valid      = 1'b0;
      endcase
   end

   assign set_cc = (icode == OPQ) & op_valid & ~cc_inhibit & ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
      end else if (set_cc) begin
         flags <= flags_next;
      end
   end

   assign zf = flags.zf;
   assign sf = flags.sf;
   assign of = flags.of;

   cond_eval u_cond_eval (
      .ifun     (ifun),
      .zf       (flags.zf),
      .sf       (flags.sf),
      .of       (flags.of),
      .cnd      (cnd_raw),
      .bad_cond (bad_raw)
   );

   assign is_cond  = is_cond_icode(icode);
   assign cnd      = is_cond & cnd_raw;
   assign bad_cond = is_cond & bad_raw;

`ifdef CC_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_upd_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         if (set_cc) begin
            cc_upd_cnt <= cc_upd_cnt + 1'b1;
         end
         if (!stall && (icode == JXX) && cnd) begin
            taken_cnt <= taken_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule
